// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register file and ALU.
// Executes one externally supplied control word per clock; returns op/funct/zero to the controller.
module mc_datapath #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             memwrite,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             branch,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [1:0]       aluop,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] readdata
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NONE
  } alu_op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] rf_q [32];
  logic [WIDTH-1:0] rf_d [32];

  logic [WIDTH-1:0] sign_imm;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       wr_addr;
  logic             pc_en;
  logic             slt_bit;
  alu_op_e          alu_ctl;

  always_comb begin
    sign_imm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    src_a    = alusrca ? a_q : pc_q;
    case (alusrcb)
      2'b00:   src_b = b_q;
      2'b01:   src_b = WIDTH'(4);
      2'b10:   src_b = sign_imm;
      default: src_b = sign_imm << 2;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    case (aluop)
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (ir_q[5:0])
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_NONE;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    slt_bit = $signed(src_a) < $signed(src_b);
    case (alu_ctl)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    case (pcsrc)
      2'b01:   pc_next = aluout_q;
      2'b10:   pc_next = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};
      default: pc_next = alu_result;
    endcase
    pc_en = pcwrite | (branch & zero);
  end

  // r0 reads as zero regardless of array contents
  always_comb begin
    rd_a    = (ir_q[25:21] == 5'd0) ? '0 : rf_q[ir_q[25:21]];
    rd_b    = (ir_q[20:16] == 5'd0) ? '0 : rf_q[ir_q[20:16]];
    wr_addr = regdst ? ir_q[15:11] : ir_q[20:16];
    wr_data = memtoreg ? mdr_q : aluout_q;
  end

  always_comb begin
    pc_d     = pc_en ? pc_next : pc_q;
    ir_d     = irwrite ? readdata : ir_q;
    mdr_d    = readdata;
    a_d      = rd_a;
    b_d      = rd_b;
    aluout_d = alu_result;
    rf_d     = rf_q;
    if (regwrite && (wr_addr != 5'd0)) begin
      rf_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC[WIDTH-1:0];
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      rf_q     <= rf_d;
    end
  end

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;
  assign mem_we    = memwrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench acts as controller and memory for mc_datapath and checks it against an
// instruction-level model (register array, PC, data words) after every step.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc, aluop;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata, readdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mc_datapath #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .branch(branch), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .op(op), .funct(funct), .zero(zero),
    .adr(adr), .writedata(writedata), .mem_we(mem_we), .readdata(readdata)
  );

  // Data memory; the instruction being executed is presented at its own PC.
  logic [31:0] mem [1024] = '{default: 32'h0};
  logic [31:0] fetch_pc  = 32'hFFFF_FFFF;
  logic [31:0] fetch_ins = 32'h0;
  assign readdata = (adr == fetch_pc) ? fetch_ins : mem[adr[11:2]];
  always @(posedge clk) if (mem_we) mem[adr[11:2]] <= writedata;

  logic [31:0] m_rf   [32];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_pc;
  int n_cmp = 0;
  int n_err = 0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11, S_JR = 12, S_IDLE = 13;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  function automatic logic [31:0] r_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {o, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  task automatic drive(input int st, input logic rst);
    {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst} = '0;
    alusrcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
    reset = rst;
    case (st)
      S_FETCH:  begin irwrite = 1; pcwrite = 1; alusrcb = 2'b01; end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin alusrca = 1; alusrcb = 2'b10; end
      S_MEMRD:  iord = 1;
      S_MEMWB:  begin regwrite = 1; memtoreg = 1; end
      S_MEMWR:  begin iord = 1; memwrite = 1; end
      S_EXEC:   begin alusrca = 1; aluop = 2'b10; end
      S_ALUWB:  begin regwrite = 1; regdst = 1; end
      S_BRANCH: begin alusrca = 1; aluop = 2'b01; pcsrc = 2'b01; branch = 1; end
      S_ADDIEX: begin alusrca = 1; alusrcb = 2'b10; end
      S_ADDIWB: regwrite = 1;
      S_JUMP:   begin pcwrite = 1; pcsrc = 2'b10; end
      S_JR:     begin alusrca = 1; pcwrite = 1; end
      default:  ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int st);
    drive(st, 1'b0);
    #1;
    chk("mem_we", 32'(mem_we), 32'(st == S_MEMWR));
    tick();
  endtask

  task automatic wreg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
    chk("rf_dest", dut.rf_q[r], m_rf[r]);
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  o, f;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] npc, res, addr;
    o = ins[31:26]; f = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; imm = ins[15:0];
    fetch_pc = m_pc; fetch_ins = ins;
    cyc(S_FETCH);
    npc = m_pc + 32'd4;
    chk("ir", dut.ir_q, ins);
    chk("pc_fetch", dut.pc_q, npc);
    chk("op", 32'(op), 32'(o));
    chk("funct", 32'(funct), 32'(f));
    cyc(S_DECODE);
    chk("aluout_dec", dut.aluout_q, npc + (sext(imm) << 2));
    case (o)
      6'h00: begin
        if (f == 6'h08) begin
          cyc(S_JR);
          npc = m_rf[rs] + m_rf[rt];
        end else begin
          res = r_alu(f, m_rf[rs], m_rf[rt]);
          drive(S_EXEC, 1'b0);
          #1;
          chk("zero_ex", 32'(zero), 32'(res == 32'd0));
          tick();
          chk("aluout_ex", dut.aluout_q, res);
          cyc(S_ALUWB);
          wreg(rd, res);
        end
      end
      6'h23: begin
        addr = m_rf[rs] + sext(imm);
        cyc(S_MEMADR);
        cyc(S_MEMRD);
        cyc(S_MEMWB);
        wreg(rt, m_dmem[addr[11:2]]);
      end
      6'h2b: begin
        addr = m_rf[rs] + sext(imm);
        cyc(S_MEMADR);
        drive(S_MEMWR, 1'b0);
        #1;
        chk("sw_mem_we", 32'(mem_we), 32'd1);
        chk("sw_adr", adr, addr);
        chk("sw_wdata", writedata, m_rf[rt]);
        tick();
        m_dmem[addr[11:2]] = m_rf[rt];
      end
      6'h04: begin
        drive(S_BRANCH, 1'b0);
        #1;
        chk("zero_beq", 32'(zero), 32'(m_rf[rs] == m_rf[rt]));
        tick();
        if (m_rf[rs] == m_rf[rt]) npc = npc + (sext(imm) << 2);
      end
      6'h08: begin
        cyc(S_ADDIEX);
        cyc(S_ADDIWB);
        wreg(rt, m_rf[rs] + sext(imm));
      end
      6'h02: begin
        cyc(S_JUMP);
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    m_pc = npc;
    chk("pc", dut.pc_q, m_pc);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0]  f;
    int          off;
    logic [4:0]  rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (m_pc[11:0] >= 12'h600) return j_ins(26'($urandom_range(0, 255)));
    case ($urandom_range(0, 9))
      0, 1: begin
        case ($urandom_range(0, 4))
          0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; default: f = 6'h2a;
        endcase
        return r_ins(rs, rt, rd, f);
      end
      2: begin
        f = 6'h3f;
        for (int k = 0; k < 8; k++) begin
          f = 6'($urandom_range(0, 63));
          if (!(f inside {6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a})) break;
          f = 6'h3f;
        end
        return r_ins(rs, rt, rd, f);
      end
      3, 4: return i_ins(6'h08, rs, rt, 16'($urandom));
      5:    return i_ins(6'h23, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 63)));
      6:    return i_ins(6'h2b, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 63)));
      7, 8: begin
        off = int'($urandom_range(0, 16)) - 8;
        return i_ins(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), off[15:0]);
      end
      default: return j_ins(26'($urandom_range(0, 255)));
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_pc = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_dmem[i] = 32'h0;
    model_reset();

    drive(S_IDLE, 1'b1);
    tick();
    // reset with every enable high must still win
    drive(S_IDLE, 1'b1);
    {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, memtoreg, regdst} = '1;
    alusrcb = 2'b11; pcsrc = 2'b11; aluop = 2'b11;
    tick();
    drive(S_IDLE, 1'b0);
    #1;
    chk("rst_pc", dut.pc_q, 32'h0);
    chk("rst_ir", dut.ir_q, 32'h0);
    chk("rst_aluout", dut.aluout_q, 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_funct", 32'(funct), 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    for (int i = 0; i < 32; i++) chk("rst_rf", dut.rf_q[i], 32'h0);
    memwrite = 1'b1;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd1);
    memwrite = 1'b0;
    tick();

    run_instr(i_ins(6'h08, 5'd0, 5'd1, 16'd5));
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd7));
    run_instr(32'h0022_1820);
    chk("add_r3", dut.rf_q[3], 32'd12);
    run_instr(i_ins(6'h2b, 5'd0, 5'd3, 16'd8));
    run_instr(i_ins(6'h23, 5'd0, 5'd4, 16'd8));
    chk("lw_r4", dut.rf_q[4], 32'd12);
    run_instr(j_ins(26'h4));
    run_instr(i_ins(6'h04, 5'd1, 5'd1, 16'd3));
    chk("beq_taken", dut.pc_q, 32'h20);
    run_instr(j_ins(26'h4));
    run_instr(i_ins(6'h04, 5'd1, 5'd2, 16'd3));
    chk("beq_not_taken", dut.pc_q, 32'h14);
    run_instr(i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF));
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd1));
    run_instr(r_ins(5'd1, 5'd2, 5'd3, 6'h2a));
    chk("slt_r3", dut.rf_q[3], 32'd1);
    run_instr(i_ins(6'h08, 5'd0, 5'd5, 16'hFFFF));
    chk("addi_r5", dut.rf_q[5], 32'hFFFF_FFFF);
    run_instr(i_ins(6'h08, 5'd0, 5'd0, 16'd9));
    chk("r0_zero", dut.rf_q[0], 32'h0);
    run_instr(r_ins(5'd1, 5'd2, 5'd6, 6'h3f));
    run_instr(i_ins(6'h08, 5'd0, 5'd7, 16'h3000));
    repeat (16) run_instr(r_ins(5'd7, 5'd7, 5'd7, 6'h20));
    run_instr(r_ins(5'd7, 5'd0, 5'd0, 6'h08));
    chk("jr_pc", dut.pc_q, 32'h3000_0000);
    run_instr(j_ins(26'h10));
    chk("j_pc", dut.pc_q, 32'h3000_0040);

    // lw abandoned by reset during MemRd
    fetch_pc = m_pc; fetch_ins = i_ins(6'h23, 5'd0, 5'd4, 16'd8);
    cyc(S_FETCH);
    cyc(S_DECODE);
    cyc(S_MEMADR);
    drive(S_MEMRD, 1'b1);
    tick();
    model_reset();
    chk("rstmid_pc", dut.pc_q, 32'h0);
    chk("rstmid_r4", dut.rf_q[4], 32'h0);
    cyc(S_IDLE);
    chk("rstmid_r4_after", dut.rf_q[4], 32'h0);
    chk("rstmid_pc_after", dut.pc_q, 32'h0);

    for (int n = 0; n < 300; n++) run_instr(rand_ins());
    for (int i = 0; i < 32; i++) chk("final_rf", dut.rf_q[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multi-cycle MIPS datapath that executes the control word produced by the main control FSM each cycle. It holds PC, IR, MDR, A, B and ALUOut, a 32x32 register file, the ALU and its funct decode, and the unified instruction/data memory port. It returns `op`, `funct` and `zero` to the control side. All architectural and non-architectural state lives here; the controller holds only its state register.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `pcwrite`, `memwrite`, `irwrite`, `regwrite`, `alusrca`, `branch`, `iord`, `memtoreg`, `regdst`  in  1 each: control word from the controller.
- `alusrcb`  in  2: ALU B select.
- `pcsrc`  in  2: next-PC select.
- `aluop`  in  2: 00 add, 01 sub, 10 decode funct, 11 add.
- `op`  out  6: IR[31:26].
- `funct`  out  6: IR[5:0].
- `zero`  out  1: ALU result == 0, combinational.
- `adr`  out  32: memory address.
- `writedata`  out  32: memory write data, equals B.
- `mem_we`  out  1: equals `memwrite`.
- `readdata`  in  32: memory read data, combinational w.r.t. `adr`.

## Operation
- `adr` = `iord` ? ALUOut : PC.
- IR <= `readdata` when `irwrite`; otherwise IR holds.
- MDR, A, B and ALUOut load every cycle, unconditionally:
  - MDR <= `readdata`.
  - A <= RF[IR[25:21]].
  - B <= RF[IR[20:16]].
  - ALUOut <= ALU result.
- SrcA = `alusrca` ? A : PC.
- SrcB select:
  - 00: B.
  - 01: 32'd4.
  - 10: SignImm, where SignImm = sign-extend IR[15:0].
  - 11: SignImm << 2.
- ALU control:
  - `aluop` 00 or 11: add.
  - `aluop` 01: sub.
  - `aluop` 10, by funct:
    - 100000 add.
    - 100010 sub.
    - 100100 and.
    - 100101 or.
    - 101010 slt (signed, result 1 or 0).
    - any other funct: result 32'h0.
- Add and sub wrap modulo 2^32; there is no overflow trap.
- Next PC select:
  - `pcsrc` 00: ALU result.
  - 01: ALUOut.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: ALU result.
- PC enable = `pcwrite` | (`branch` & `zero`).
- Register file:
  - Write port: when `regwrite`, writes RF[`regdst` ? IR[15:11] : IR[20:16]] <= (`memtoreg` ? MDR : ALUOut).
  - Writes to r0 are discarded; reads of r0 always return 0.
  - Reads are combinational from the array contents before the current edge. A same-cycle write and read of the same register captures the old value into A/B.
- Controller sequence for each instruction class:
  - Fetch: IR <= mem[PC], PC <= PC+4.
  - Decode: ALUOut <= PC + (SignImm << 2).
  - R-type: Execute then ALU writeback.
  - lw: MemAdr, MemRd, MemWB (writes MDR to rt).
  - sw: MemAdr, MemWr (mem[ALUOut] <= B).
  - beq: sub A-B; if `zero`, PC <= ALUOut.
  - addi: add A+SignImm into ALUOut, then write rt.
  - j: PC <= jump target.

## Timing
- Reset has priority over every enable in the same cycle. The cycle after `reset` is sampled high:
  - PC = `RESET_PC`.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 RF entries = 0.
  - `op` = 0, `funct` = 0.
  - `zero` reflects ALU(PC=RESET_PC, SrcB) and is combinational.
  - `adr` = `RESET_PC` when `iord`=0.
  - `mem_we` follows `memwrite`.
- Reset asserted mid-instruction abandons the instruction; there are no partial register-file or PC effects after that edge.
- Every register updates exactly one edge after its enable and inputs are sampled. All outputs other than register contents are combinational.
- `branch` and `pcwrite` both high: PC is written once, with the `pcsrc` value.
- `irwrite` and `pcwrite` both high (Fetch): IR receives the word at the old PC and PC advances on the same edge.
- No handshakes: the memory must return `readdata` within the same cycle.

## Test plan
- Reset: assert `reset` 1 cycle with all enables high. Required: PC=0, IR=0, no RF write, `op`=0.
- Fetch plus R-type:
  - Preload r1=5 and r2=7.
  - Drive Fetch, Decode, Execute, ALUWB for `add r3,r1,r2` (32'h00221820).
  - Required: PC=4, r3=12, 4 cycles total.
  - Repeat with funct 101010 and r1=-1, r2=1. Required: r3=1.
- lw/sw:
  - Run `sw r3,8(r0)`. Required: `mem_we`=1 only in MemWr, `adr`=8, `writedata`=12.
  - Then run `lw r4,8(r0)`. Required: r4=12 after MemWB.
- beq:
  - Run `beq r1,r1,+3` at PC=0x10. Required: PC=0x20.
  - Run `beq r1,r2,+3`. Required: PC=0x14, PC not written in the Branch state.
- j and addi:
  - Run `j 0x40` (IR[25:0]=0x10) at PC=0x3000_0000. Required: PC=0x3000_0040.
  - Run `addi r5,r0,-1`. Required: r5=32'hFFFF_FFFF.
- Boundaries:
  - `addi r0,r0,9`. Required: r0 still reads 0.
  - `reset` asserted in MemRd. Required: lw target unchanged, PC=`RESET_PC` next cycle.
  - Unknown funct 111111 under `aluop`=10. Required: ALUOut=0, `zero`=1.
